// File: rtl/reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_file_wb                                               |
// | Brief    : ID-stage register file with same-cycle write-back bypass, |
// |            per-register outstanding-write scoreboard, RAW/saturation |
// |            stall, wrapping write-back counter and sticky error flag. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module reg_file_wb #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_REG = 5,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_to_reg_2_wb,
  input  logic [D_SIZE-1:0]        alu_out_f_mem_2_wb,
  input  logic [ADDR_LINE_REG-1:0] alu_add_f_mem_2_wb,
  input  logic [ADDR_LINE_REG-1:0] rs_addr,
  input  logic [ADDR_LINE_REG-1:0] rt_addr,
  output logic [D_SIZE-1:0]        rs_data,
  output logic [D_SIZE-1:0]        rt_data,
  input  logic                     issue_valid,
  input  logic                     issue_rs_used,
  input  logic                     issue_rt_used,
  input  logic                     issue_wr,
  input  logic [ADDR_LINE_REG-1:0] issue_dest,
  output logic                     stall,
  output logic [CNT_W-1:0]         wb_count,
  output logic                     sb_err
);

  localparam int NREG = 1 << ADDR_LINE_REG;

  logic [D_SIZE-1:0] regs_q [NREG];
  logic [1:0]        pend_q [NREG];
  logic [1:0]        pend_d [NREG];
  logic [CNT_W-1:0]  wb_count_q;
  logic              sb_err_q;
  logic              sb_err_d;

  logic              wr_en;
  logic [NREG-1:0]   wbhit;
  logic [NREG-1:0]   eff_nz;
  logic              accept;

  // A write-back lands in the array only for a non-zero destination.
  assign wr_en = mem_to_reg_2_wb && (alu_add_f_mem_2_wb != '0);

  // Per-register write-back hit and "effective pending > 0" (pend minus hit, floored).
  always_comb begin
    wbhit  = '0;
    eff_nz = '0;
    for (int r = 1; r < NREG; r++) begin
      wbhit[r]  = wr_en && (alu_add_f_mem_2_wb == ADDR_LINE_REG'(r));
      eff_nz[r] = wbhit[r] ? (pend_q[r] > 2'd1) : (pend_q[r] != 2'd0);
    end
  end

  // Read ports: register 0 reads zero, in-flight write-back is bypassed.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0)
      rs_data = (wr_en && alu_add_f_mem_2_wb == rs_addr) ? alu_out_f_mem_2_wb : regs_q[rs_addr];
    if (rt_addr != '0)
      rt_data = (wr_en && alu_add_f_mem_2_wb == rt_addr) ? alu_out_f_mem_2_wb : regs_q[rt_addr];
  end

  // Hazard detection; saturation deliberately looks at pend, not the bypass-adjusted count.
  always_comb begin
    stall = 1'b0;
    if (issue_valid) begin
      if (issue_rs_used && eff_nz[rs_addr])
        stall = 1'b1;
      if (issue_rt_used && eff_nz[rt_addr])
        stall = 1'b1;
      if (issue_wr && (issue_dest != '0) && (pend_q[issue_dest] == 2'd3))
        stall = 1'b1;
    end
    accept = issue_valid && !stall && issue_wr && (issue_dest != '0);
  end

  // Scoreboard next state: accept and write-back to the same register cancel out.
  always_comb begin
    pend_d[0] = 2'd0;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (accept && (issue_dest == ADDR_LINE_REG'(r)) && !wbhit[r])
        pend_d[r] = pend_q[r] + 2'd1;
      else if (wbhit[r] && !(accept && (issue_dest == ADDR_LINE_REG'(r))) && (pend_q[r] != 2'd0))
        pend_d[r] = pend_q[r] - 2'd1;
    end
    sb_err_d = sb_err_q || (wr_en && (pend_q[alu_add_f_mem_2_wb] == 2'd0));
  end

  // Register array, scoreboard, counter and error flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= 2'd0;
      end
      wb_count_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_q[alu_add_f_mem_2_wb] <= alu_out_f_mem_2_wb;
        wb_count_q                 <= wb_count_q + 1'b1;
      end
      for (int r = 0; r < NREG; r++)
        pend_q[r] <= pend_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign wb_count = wb_count_q;
  assign sb_err   = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reg_file_wb                                            |
// | Brief    : Self-checking bench for reg_file_wb with a behavioural    |
// |            scoreboard/register model, directed and random stimulus.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_reg_file_wb;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_reg_2_wb;
  logic [31:0] alu_out_f_mem_2_wb;
  logic [4:0]  alu_add_f_mem_2_wb;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        issue_valid, issue_rs_used, issue_rt_used, issue_wr;
  logic [4:0]  issue_dest;
  logic        stall;
  logic [15:0] wb_count;
  logic        sb_err;

  reg_file_wb #(.D_SIZE(32), .ADDR_LINE_REG(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .mem_to_reg_2_wb(mem_to_reg_2_wb),
    .alu_out_f_mem_2_wb(alu_out_f_mem_2_wb),
    .alu_add_f_mem_2_wb(alu_add_f_mem_2_wb),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_rs_used(issue_rs_used),
    .issue_rt_used(issue_rt_used), .issue_wr(issue_wr),
    .issue_dest(issue_dest),
    .stall(stall), .wb_count(wb_count), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_regs [NREG];
  int          m_pend [NREG];
  int unsigned m_cnt;
  bit          m_err;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hit(input int r);
    return (mem_to_reg_2_wb && int'(alu_add_f_mem_2_wb) == r && r != 0) ? 1 : 0;
  endfunction

  function automatic int eff(input int r);
    int e;
    e = m_pend[r] - hit(r);
    return (e < 0) ? 0 : e;
  endfunction

  function automatic logic m_stall();
    if (!issue_valid) return 1'b0;
    if (issue_rs_used && eff(int'(rs_addr)) > 0) return 1'b1;
    if (issue_rt_used && eff(int'(rt_addr)) > 0) return 1'b1;
    if (issue_wr && issue_dest != 0 && m_pend[issue_dest] == 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'd0;
    if (hit(a) == 1) return alu_out_f_mem_2_wb;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = 0;
      m_pend[r] = 0;
    end
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic compare_all();
    check_eq("rs_data",  rs_data,  m_read(int'(rs_addr)));
    check_eq("rt_data",  rt_data,  m_read(int'(rt_addr)));
    check_eq("stall",    {31'd0, stall},  {31'd0, m_stall()});
    check_eq("wb_count", {16'd0, wb_count}, m_cnt & 32'hFFFF);
    check_eq("sb_err",   {31'd0, sb_err}, {31'd0, m_err});
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  // Advance the model with the inputs held across the rising edge.
  task automatic commit();
    bit acc;
    int w, d;
    @(posedge clk);
    acc = issue_valid && !m_stall() && issue_wr && issue_dest != 0;
    w = int'(alu_add_f_mem_2_wb);
    d = int'(issue_dest);
    if (hit(w) == 1) begin
      if (m_pend[w] == 0) m_err = 1;
      if (!(acc && d == w) && m_pend[w] > 0) m_pend[w]--;
      m_regs[w] = alu_out_f_mem_2_wb;
      m_cnt = (m_cnt + 1) & 32'hFFFF;
    end
    if (acc && hit(d) == 0) m_pend[d]++;
    #1;
  endtask

  task automatic cycle();
    sample();
    commit();
  endtask

  task automatic idle();
    mem_to_reg_2_wb = 0; alu_out_f_mem_2_wb = 0; alu_add_f_mem_2_wb = 0;
    rs_addr = 0; rt_addr = 0;
    issue_valid = 0; issue_rs_used = 0; issue_rt_used = 0; issue_wr = 0; issue_dest = 0;
  endtask

  task automatic wb(input int a, input logic [31:0] d);
    mem_to_reg_2_wb = 1; alu_add_f_mem_2_wb = 5'(a); alu_out_f_mem_2_wb = d;
  endtask

  task automatic iss(input bit wr, input int dest, input bit rsu, input int rs);
    issue_valid = 1; issue_wr = wr; issue_dest = 5'(dest);
    issue_rs_used = rsu; rs_addr = 5'(rs);
  endtask

  int unsigned cnt_save;
  int          pl [$];

  initial begin
    idle();
    reset = 1;
    model_reset();
    #1;
    check_eq("reset_rs", rs_data, 32'd0);
    check_eq("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // Register 0 write-back is discarded and not counted
    wb(0, 32'hDEADBEEF);
    cycle();
    idle();
    sample();
    check_eq("r0_read", rs_data, 32'd0);
    check_eq("r0_wbcnt", {16'd0, wb_count}, 32'd0);
    check_eq("r0_sberr", {31'd0, sb_err}, 32'd0);
    commit();

    // Simple RAW on register 5
    iss(1, 5, 0, 0); cycle();
    idle(); iss(0, 0, 1, 5);
    sample(); check_eq("raw_stall1", {31'd0, stall}, 32'd1); commit();
    cycle();
    wb(5, 32'h1234);
    sample();
    check_eq("raw_stall_wb", {31'd0, stall}, 32'd0);
    check_eq("raw_bypass", rs_data, 32'h1234);
    commit();
    idle(); iss(0, 0, 1, 5);
    sample(); check_eq("raw_clear", {31'd0, stall}, 32'd0); check_eq("raw_arr", rs_data, 32'h1234); commit();

    // Saturation on register 7
    idle();
    for (int i = 0; i < 3; i++) begin iss(1, 7, 0, 0); cycle(); end
    sample(); check_eq("sat_stall", {31'd0, stall}, 32'd1); commit();
    wb(7, 32'h77);
    sample(); check_eq("sat_stall_wb", {31'd0, stall}, 32'd1); commit();
    idle(); iss(1, 7, 0, 0);
    sample(); check_eq("sat_accept", {31'd0, stall}, 32'd0); commit();
    idle();
    for (int i = 0; i < 3; i++) begin wb(7, 32'h70 + i); cycle(); end

    // Simultaneous accept and write-back on register 3
    idle(); iss(1, 3, 0, 0); cycle();
    cnt_save = m_cnt;
    wb(3, 32'h33); cycle();
    idle(); iss(0, 0, 1, 3);
    sample();
    check_eq("sim_wbcnt", {16'd0, wb_count}, (cnt_save + 1) & 32'hFFFF);
    check_eq("sim_pend1", {31'd0, stall}, 32'd1);
    commit();
    idle(); wb(3, 32'h34); cycle();

    // Spurious write-back to register 9
    idle(); wb(9, 32'hA5); cycle();
    idle(); iss(0, 0, 1, 9);
    sample();
    check_eq("spur_data", rs_data, 32'hA5);
    check_eq("spur_err", {31'd0, sb_err}, 32'd1);
    check_eq("spur_pend0", {31'd0, stall}, 32'd0);
    commit();

    // Randomised traffic, write-backs biased towards pending registers
    for (int i = 0; i < 3000; i++) begin
      idle();
      issue_valid   = 1'($urandom);
      issue_wr      = 1'($urandom);
      issue_rs_used = 1'($urandom);
      issue_rt_used = 1'($urandom);
      issue_dest    = 5'($urandom_range(0, 7));
      rs_addr       = 5'($urandom_range(0, 7));
      rt_addr       = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6) begin
        pl.delete();
        for (int r = 1; r < NREG; r++) if (m_pend[r] > 0) pl.push_back(r);
        if (pl.size() > 0 && $urandom_range(0, 9) < 9)
          wb(pl[$urandom_range(0, pl.size() - 1)], $urandom);
        else
          wb($urandom_range(0, 31), $urandom);
      end
      cycle();
    end

    // Counter wrap after 65536 write-backs
    idle();
    cnt_save = m_cnt;
    for (int i = 0; i < 65536; i++) begin
      wb((i % 31) + 1, 32'(i));
      @(posedge clk);
      if (hit(int'(alu_add_f_mem_2_wb)) == 1) begin
        if (m_pend[alu_add_f_mem_2_wb] > 0) m_pend[alu_add_f_mem_2_wb]--; else m_err = 1;
        m_regs[alu_add_f_mem_2_wb] = alu_out_f_mem_2_wb;
        m_cnt = (m_cnt + 1) & 32'hFFFF;
      end
      #1;
    end
    idle();
    sample(); check_eq("wrap_cnt", {16'd0, wb_count}, cnt_save); commit();

    // Mid-operation reset with two writes outstanding on register 4
    iss(1, 4, 0, 0); cycle(); cycle();
    idle(); iss(0, 0, 1, 4);
    sample(); check_eq("pre_rst_stall", {31'd0, stall}, 32'd1); commit();
    reset = 1;
    model_reset();
    #1;
    compare_all();
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    sample(); check_eq("post_rst_stall", {31'd0, stall}, 32'd0); commit();
    idle(); wb(4, 32'h44); cycle();
    idle();
    sample(); check_eq("post_rst_err", {31'd0, sb_err}, 32'd1); commit();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
